uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares a single UART serial output between `NUM_REQ` byte producers. It arbitrates among requesters using a valid/ready handshake and latches the winning byte. It then sequences the frame: one start bit, 8 data bits LSB-first, one stop bit, each bit held for `CLKS_PER_BIT` clocks. It sits between the on-chip byte sources and the board TX pin, and replaces per-source free-running transmitters.

---
 rtl/uart_tx_scheduler.sv | 150 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing one UART TX line among NUM_REQ byte producers
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic [IDW-1:0]       grant_id_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic           tx_q, tx_d;
  logic [NUM_REQ-1:0] ready_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [7:0]     req_bytes [NUM_REQ];

  // Unpack the flat data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data_i[8*g+7:8*g];
  end

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDW'(cand);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Frame sequencing: grant in IDLE, then start, 8 data bits LSB-first, stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ready_d = '0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ready_d[win_idx] = 1'b1;
          shift_d          = req_bytes[win_idx];
          ptr_d            = win_idx;
          gid_d            = win_idx;
          cnt_d            = '0;
          state_d          = START;
        end
      end
      START: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line is registered from the next state so it changes one cycle after the handshake.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      ptr_q   <= IDW'(NUM_REQ - 1);
      gid_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      tx_q    <= tx_d;
    end
  end

  assign req_ready_o = reset_i ? '0 : ready_d;
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [1:0]     grant_id;

  uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(C)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the line is a queue of future tx levels, one per cycle.
  bit        line [$];
  int        m_ptr;
  int        m_gid;
  bit        pend [N];
  logic [7:0] byt [N];
  int        grants;

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input int p_new, input int p_wd, input bit rst);
    logic [N-1:0] exp_ready;
    logic         exp_tx;
    logic         exp_busy;
    int           win;
    @(posedge clk);
    #1;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        if ($urandom_range(p_new - 1) == 0) begin
          pend[i] = 1'b1;
          byt[i]  = 8'($urandom);
        end
      end else if (p_wd > 0 && $urandom_range(p_wd - 1) == 0) begin
        pend[i] = 1'b0;
      end
      req_valid[i]       = pend[i];
      req_data[8*i +: 8] = pend[i] ? byt[i] : 8'($urandom);
    end
    #1;
    exp_tx    = (line.size() != 0) ? line[0] : 1'b1;
    exp_busy  = (line.size() != 0);
    exp_ready = '0;
    win       = -1;
    if (!rst && line.size() == 0) begin
      win = pick(req_valid);
      if (win >= 0) exp_ready[win] = 1'b1;
    end
    check("tx", 32'(tx), 32'(exp_tx));
    check("busy", 32'(busy), 32'(exp_busy));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (line.size() != 0) void'(line.pop_front());
    if (rst) begin
      line.delete();
      m_ptr = N - 1;
      m_gid = 0;
    end else if (win >= 0) begin
      for (int b = 0; b < 10; b++) begin
        bit lvl;
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[win][b-1];
        repeat (C) line.push_back(lvl);
      end
      m_ptr   = win;
      m_gid   = win;
      pend[win] = 1'b0;
      grants++;
    end
  endtask

  initial begin
    int guard;
    reset     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    m_ptr     = N - 1;
    m_gid     = 0;
    grants    = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      byt[i]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;

    // Sparse traffic with withdrawals and rare resets.
    for (int c = 0; c < 3000; c++) step(30, 40, $urandom_range(499) == 0);
    // Full contention: every requester re-asserts immediately.
    for (int c = 0; c < 400; c++) step(1, 0, 1'b0);
    // Reset in the middle of data bit 3 of a frame.
    guard = 0;
    while (line.size() != 22 && guard < 1000) begin
      step(2, 0, 1'b0);
      guard++;
    end
    check("midframe_reached", 32'(line.size()), 32'd22);
    step(2, 0, 1'b1);
    // Dense traffic afterwards.
    for (int c = 0; c < 2000; c++) step(3, 100, $urandom_range(999) == 0);
    check("grants_seen", 32'(grants > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
